// File: rtl/tawas_lsu_if.sv
// ---------------------------------------------------------------------------
// tawas_lsu_if
//   Data-bus bundle between the load/store unit and a synchronous data memory.
//
//   d_addr  word-aligned byte address ([1:0] always 0)
//   d_cs    access strobe, one cycle per access
//   d_we    1 = write, 0 = read
//   d_mask  byte enables, bit n covers d_out/d_in[8n+7:8n]
//   d_out   write data, replicated across lanes
//   d_in    read data, returned the cycle after d_cs
//
//   master : the load/store unit (drives the request, consumes d_in)
//   slave  : the memory (consumes the request, drives d_in)
// ---------------------------------------------------------------------------
interface tawas_lsu_if #(
  parameter int ADDR_W = 32
);
  logic [ADDR_W-1:0] d_addr;
  logic              d_cs;
  logic              d_we;
  logic [3:0]        d_mask;
  logic [31:0]       d_out;
  logic [31:0]       d_in;

  modport master (
    output d_addr,
    output d_cs,
    output d_we,
    output d_mask,
    output d_out,
    input  d_in
  );

  modport slave (
    input  d_addr,
    input  d_cs,
    input  d_we,
    input  d_mask,
    input  d_out,
    output d_in
  );
endinterface

// File: rtl/tawas_lsu.sv
// ---------------------------------------------------------------------------
// tawas_lsu
//   Load/store unit for the two-slice Tawas core. One op may be issued every
//   cycle. In the issue cycle the unit selects the pointer and store-source
//   registers, computes the effective address and drives one data-bus access.
//   One cycle later (the opposite slice) it returns the pointer update and/or
//   the extended load data to the register file. There are no stalls.
//
// Ports
//   clk_i, rst_i            clock, synchronous active-high reset
//   slice_i                 current thread slice (timing reference only)
//   ls_op_*_i               op descriptor for the issue cycle
//   ls_ptr_sel_o / ls_ptr_i     pointer register read select / value
//   ls_store_sel_o / ls_store_i store source register read select / value
//   ls_ptr_upd_*_o          pointer write-back (valid, register, value)
//   ls_load_*_o             load write-back (valid, register, value)
//   ls_fault_o              pulse in write-back cycle for a dropped op
//   bus                     data-bus master port
// ---------------------------------------------------------------------------
module tawas_lsu #(
  parameter int ADDR_W = 32
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        slice_i,

  input  logic        ls_op_vld_i,
  input  logic        ls_op_store_i,
  input  logic [1:0]  ls_op_size_i,
  input  logic        ls_op_signed_i,
  input  logic [2:0]  ls_op_ptr_i,
  input  logic [2:0]  ls_op_reg_i,
  input  logic [4:0]  ls_op_offset_i,
  input  logic        ls_op_upd_i,

  output logic [2:0]  ls_ptr_sel_o,
  input  logic [31:0] ls_ptr_i,
  output logic [2:0]  ls_store_sel_o,
  input  logic [31:0] ls_store_i,

  output logic        ls_ptr_upd_vld_o,
  output logic [2:0]  ls_ptr_upd_sel_o,
  output logic [31:0] ls_ptr_upd_o,

  output logic        ls_load_vld_o,
  output logic [2:0]  ls_load_sel_o,
  output logic [31:0] ls_load_o,

  output logic        ls_fault_o,

  tawas_lsu_if.master bus
);

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

  // -------------------------------------------------------------------------
  // Issue stage (combinational)
  // -------------------------------------------------------------------------
  logic [31:0] ea;
  logic        misalign;
  logic        issue_ok;
  logic [3:0]  mask_raw;
  logic [31:0] dout_raw;

  assign ls_ptr_sel_o   = ls_op_ptr_i;
  assign ls_store_sel_o = ls_op_reg_i;

  // Offset is scaled by access size; 32-bit add wraps naturally.
  assign ea = ls_ptr_i + (32'(ls_op_offset_i) << ls_op_size_i);

  always_comb begin
    misalign = 1'b0;
    case (ls_op_size_i)
      SZ_BYTE: misalign = 1'b0;
      SZ_HALF: misalign = ea[0];
      SZ_WORD: misalign = |ea[1:0];
      default: misalign = 1'b1;  // reserved size
    endcase
  end

  // Reset blocks the bus access combinationally so nothing leaks while the
  // stage is being cleared.
  assign issue_ok = ls_op_vld_i & ~misalign & ~rst_i;

  always_comb begin
    mask_raw = 4'b1111;
    dout_raw = ls_store_i;
    case (ls_op_size_i)
      SZ_BYTE: begin
        mask_raw = 4'b0001 << ea[1:0];
        dout_raw = {4{ls_store_i[7:0]}};
      end
      SZ_HALF: begin
        mask_raw = 4'b0011 << ea[1:0];
        dout_raw = {2{ls_store_i[15:0]}};
      end
      default: begin
        mask_raw = 4'b1111;
        dout_raw = ls_store_i;
      end
    endcase
  end

  assign bus.d_cs   = issue_ok;
  assign bus.d_we   = issue_ok & ls_op_store_i;
  assign bus.d_mask = issue_ok ? mask_raw : 4'b0000;
  assign bus.d_addr = issue_ok ? {ea[ADDR_W-1:2], 2'b00} : '0;
  assign bus.d_out  = (issue_ok & ls_op_store_i) ? dout_raw : 32'h0;

  // -------------------------------------------------------------------------
  // Stage register: reloaded every cycle, valid only for accepted ops.
  // -------------------------------------------------------------------------
  logic        vld_q,    vld_d;
  logic        fault_q,  fault_d;
  logic        load_q,   load_d;
  logic [1:0]  size_q,   size_d;
  logic        signed_q, signed_d;
  logic [2:0]  reg_q,    reg_d;
  logic [2:0]  ptr_q,    ptr_d;
  logic        upd_q,    upd_d;
  logic [31:0] ea_q,     ea_d;

  always_comb begin
    vld_d    = ls_op_vld_i & ~misalign;
    fault_d  = ls_op_vld_i & misalign;
    load_d   = ~ls_op_store_i;
    size_d   = ls_op_size_i;
    signed_d = ls_op_signed_i;
    reg_d    = ls_op_reg_i;
    ptr_d    = ls_op_ptr_i;
    upd_d    = ls_op_upd_i;
    ea_d     = ea;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      vld_q    <= 1'b0;
      fault_q  <= 1'b0;
      load_q   <= 1'b0;
      size_q   <= 2'd0;
      signed_q <= 1'b0;
      reg_q    <= 3'd0;
      ptr_q    <= 3'd0;
      upd_q    <= 1'b0;
      ea_q     <= 32'h0;
    end else begin
      vld_q    <= vld_d;
      fault_q  <= fault_d;
      load_q   <= load_d;
      size_q   <= size_d;
      signed_q <= signed_d;
      reg_q    <= reg_d;
      ptr_q    <= ptr_d;
      upd_q    <= upd_d;
      ea_q     <= ea_d;
    end
  end

  // -------------------------------------------------------------------------
  // Write-back stage (combinational from stage register and d_in)
  // -------------------------------------------------------------------------
  logic        wb_live;
  logic        load_wb;
  logic        ptr_wb;
  logic [31:0] lane_data;
  logic [31:0] load_ext;

  // A reset arriving in the write-back cycle must stop the regfile commit
  // at the coming edge, so the write-back strobes are gated by rst_i too.
  assign wb_live = vld_q & ~rst_i;
  assign load_wb = wb_live & load_q;
  // When a load targets its own pointer register, the load data wins.
  assign ptr_wb  = wb_live & upd_q & ~(load_q & (reg_q == ptr_q));

  // Bring the addressed lane down to bit 0; halves are aligned so a byte
  // shift by EA[1:0] also selects the correct half.
  assign lane_data = bus.d_in >> {ea_q[1:0], 3'b000};

  always_comb begin
    load_ext = bus.d_in;
    case (size_q)
      SZ_BYTE: load_ext = {{24{signed_q & lane_data[7]}},  lane_data[7:0]};
      SZ_HALF: load_ext = {{16{signed_q & lane_data[15]}}, lane_data[15:0]};
      default: load_ext = bus.d_in;
    endcase
  end

  assign ls_load_vld_o    = load_wb;
  assign ls_load_sel_o    = load_wb ? reg_q : 3'd0;
  assign ls_load_o        = load_wb ? load_ext : 32'h0;

  assign ls_ptr_upd_vld_o = ptr_wb;
  assign ls_ptr_upd_sel_o = ptr_wb ? ptr_q : 3'd0;
  assign ls_ptr_upd_o     = ptr_wb ? ea_q : 32'h0;

  assign ls_fault_o       = fault_q & ~rst_i;

  // Slice is only a timing reference (fixed one-cycle latency lines up with
  // the opposite-slice commit), so it is intentionally not consumed.
  logic unused_slice;
  assign unused_slice = slice_i;

endmodule
